// File: rtl/mult_pkg.sv
// mult_pkg: shared widths and FSM encoding for the two-requester multiplier arbiter.
package mult_pkg;
  localparam int OP_W = 4;
  localparam int P_W = 2 * OP_W;
  localparam int N_REQ = 2;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if: request/response bundle between two requesters, a consumer and the arbiter.
interface mult_arbiter_if;
  import mult_pkg::*;
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ*OP_W-1:0] req_a;
  logic [N_REQ*OP_W-1:0] req_b;
  logic rsp_valid;
  logic rsp_id;
  logic rsp_ready;
  logic [P_W-1:0] rsp_p;
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p
  );
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p
  );
endinterface

// File: rtl/mult_arbiter_multiplier.sv
// mult_arbiter_multiplier: 4x4 unsigned combinational array multiplier (shift-and-add partial products).
module mult_arbiter_multiplier
  import mult_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  output logic [P_W-1:0]  p
);
  logic [P_W-1:0] pp [OP_W];
  for (genvar i = 0; i < OP_W; i++) begin : g_pp
    assign pp[i] = b[i] ? P_W'(a) << i : '0;
  end
  always_comb begin
    p = '0;
    for (int k = 0; k < OP_W; k++) p = p + pp[k];
  end
endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one 4x4 multiplier between two requesters via IDLE/MUL/RESP FSM.
// Define MULT_ARB_ROUND_ROBIN_EN for round-robin grant; default is fixed priority to requester 0.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  mult_arbiter_if.slave    bus,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  state_t state;
  logic [OP_W-1:0] a_q, b_q;
  logic id_q, g, take;
  logic [P_W-1:0] prod;
`ifdef MULT_ARB_ROUND_ROBIN_EN
  logic ptr;
  assign g = &bus.req_valid ? ptr : bus.req_valid[1];
`else
  assign g = ~bus.req_valid[0];
`endif
  assign take = state == IDLE && !rst && |bus.req_valid;
  assign bus.req_ready = {g, ~g} & {N_REQ{take}};
  mult_arbiter_multiplier u_mul (.a(a_q), .b(b_q), .p(prod));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id <= 1'b0;
      bus.rsp_p <= '0;
      op_count <= '0;
      a_q <= '0;
      b_q <= '0;
      id_q <= 1'b0;
`ifdef MULT_ARB_ROUND_ROBIN_EN
      ptr <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (take) begin
          a_q <= bus.req_a[g*OP_W +: OP_W];
          b_q <= bus.req_b[g*OP_W +: OP_W];
          id_q <= g;
          busy <= 1'b1;
          state <= MUL;
        end
        MUL: begin
          bus.rsp_p <= prod;
          bus.rsp_id <= id_q;
          bus.rsp_valid <= 1'b1;
          state <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          busy <= 1'b0;
          op_count <= op_count + 1'b1;
`ifdef MULT_ARB_ROUND_ROBIN_EN
          ptr <= ~bus.rsp_id;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
